// File: rtl/pulse_generator.sv
// pulse_generator: programmable high/low pulse train with shadowed lengths and period counting
module pulse_generator #(
  parameter int WIDTH  = 24,
  parameter int NPER_W = 16
) (
  input  logic              clk_4mhz,
  input  logic              reset,
  input  logic              run,
  input  logic              load,
  input  logic [WIDTH-1:0]  high_len,
  input  logic [WIDTH-1:0]  low_len,
  input  logic [NPER_W-1:0] n_periods,
  output logic              cnt_out,
  output logic              en_out,
  output logic              period_done,
  output logic              busy,
  output logic              cfg_err,
  output logic [NPER_W-1:0] periods
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  ph_q, ph_d;
  logic [WIDTH-1:0]  sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic [WIDTH-1:0]  act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic [NPER_W-1:0] nper_q, nper_d, done_cnt_q, done_cnt_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cnt_out_q, cnt_out_d, en_out_q, en_out_d, busy_q, busy_d;
  logic              period_done_q, period_done_d;
  logic [NPER_W-1:0] periods_q, periods_d;

  logic [WIDTH-1:0]  eff_hi, eff_lo;
  logic [NPER_W:0]   next_cnt;
  logic              eff_zero, last, more, idle_start, start, hi_end;

  // A load on the start edge bypasses the shadow so new lengths apply at once
  always_comb begin
    eff_hi     = load ? high_len : sh_hi_q;
    eff_lo     = load ? low_len : sh_lo_q;
    eff_zero   = (eff_hi == '0) && (eff_lo == '0);
    hi_end     = (state_q == HIGH) && (ph_q == WIDTH'(1));
    last       = (hi_end && (act_lo_q == '0)) || ((state_q == LOW) && (ph_q == WIDTH'(1)));
    next_cnt   = {1'b0, done_cnt_q} + (NPER_W+1)'(1);
    more       = (nper_q == '0) || (next_cnt < {1'b0, nper_q});
    idle_start = (state_q == IDLE) && run && !eff_zero;
    start      = idle_start || (last && run && more && !eff_zero);
  end

  // Phase sequencing, shadow/active length handling and sticky config error
  always_comb begin
    sh_hi_d       = eff_hi;
    sh_lo_d       = eff_lo;
    act_hi_d      = start ? eff_hi : act_hi_q;
    act_lo_d      = start ? eff_lo : act_lo_q;
    nper_d        = idle_start ? n_periods : nper_q;
    done_cnt_d    = idle_start ? '0 : last ? (&done_cnt_q ? done_cnt_q : next_cnt[NPER_W-1:0]) : done_cnt_q;
    state_d       = start ? ((eff_hi != '0) ? HIGH : LOW) : last ? IDLE : hi_end ? LOW : state_q;
    ph_d          = start ? ((eff_hi != '0) ? eff_hi : eff_lo) : last ? '0 : hi_end ? act_lo_q :
                    (state_q == IDLE) ? ph_q : ph_q - WIDTH'(1);
    cfg_err_d     = (eff_zero && (((state_q == IDLE) && run) || last)) ? 1'b1 :
                    (load && ((high_len != '0) || (low_len != '0))) ? 1'b0 : cfg_err_q;
    cnt_out_d     = state_q == HIGH;
    en_out_d      = state_q != IDLE;
    busy_d        = state_q != IDLE;
    period_done_d = last;
    periods_d     = done_cnt_q;
  end

  // State and registered outputs
  always_ff @(posedge clk_4mhz) begin
    if (reset) begin
      state_q       <= IDLE;
      ph_q          <= '0;
      sh_hi_q       <= '0;
      sh_lo_q       <= '0;
      act_hi_q      <= '0;
      act_lo_q      <= '0;
      nper_q        <= '0;
      done_cnt_q    <= '0;
      cfg_err_q     <= 1'b0;
      cnt_out_q     <= 1'b0;
      en_out_q      <= 1'b0;
      busy_q        <= 1'b0;
      period_done_q <= 1'b0;
      periods_q     <= '0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      sh_hi_q       <= sh_hi_d;
      sh_lo_q       <= sh_lo_d;
      act_hi_q      <= act_hi_d;
      act_lo_q      <= act_lo_d;
      nper_q        <= nper_d;
      done_cnt_q    <= done_cnt_d;
      cfg_err_q     <= cfg_err_d;
      cnt_out_q     <= cnt_out_d;
      en_out_q      <= en_out_d;
      busy_q        <= busy_d;
      period_done_q <= period_done_d;
      periods_q     <= periods_d;
    end
  end

  assign cnt_out     = cnt_out_q;
  assign en_out      = en_out_q;
  assign busy        = busy_q;
  assign period_done = period_done_q;
  assign cfg_err     = cfg_err_q;
  assign periods     = periods_q;
endmodule

// File: doc/pulse_generator.md
# pulse_generator

Programmable pulse generator that drives a two-level test signal with exact high and low durations in clock cycles. It is the transmitting end of the pulse-duration measurement chain: its `cnt_out`/`en_out` pair feeds the channel selector and the duration counter, which measures high time into count+ and low time into count−. It is used for built-in self-test and calibration of the measurement path. All lengths are 24-bit, matching the counter's range.

## Interface
- `WIDTH`, 24: width of the high/low length registers.
- `NPER_W`, 16: width of the period-count request and the completed-period counter.
- `clk_4mhz`  in  1: 4 MHz system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `run`  in  1: level; 1 requests generation, 0 requests a stop at the end of the current period.
- `load`  in  1: one-cycle strobe that copies `high_len`/`low_len` into the shadow registers.
- `high_len`  in  WIDTH: high-phase length in cycles.
- `low_len`  in  WIDTH: low-phase length in cycles.
- `n_periods`  in  NPER_W: number of periods per run; 0 means continuous. Sampled on leaving IDLE.
- `cnt_out`  out  1: generated signal.
- `en_out`  out  1: gate for the measurement counter.
- `period_done`  out  1: one-cycle pulse on the last cycle of each completed period.
- `busy`  out  1: 1 whenever the state is not IDLE.
- `cfg_err`  out  1: sticky; set when a period start sees zero in both shadow lengths.
- `periods`  out  NPER_W: completed periods since the last start; saturates at all-ones.

## Operation
- **Reset values:** all outputs 0, shadow and active lengths 0, state IDLE.
- **Shadow registers:**
  - `load` copies the inputs into the shadow registers.
  - Shadow is copied to the active registers at each period start.
  - If `load` and a period start fall on the same edge, the active registers take the new input values directly (bypass).
- **States:** IDLE, HIGH, LOW, and a phase down-counter of WIDTH bits.
- **IDLE:**
  - Outputs: `cnt_out`=0, `en_out`=0.
  - When `run`=1 and the shadow lengths are not both zero:
    - latch `n_periods`;
    - clear `periods`;
    - start a period.
  - When both shadow lengths are zero: set `cfg_err` and stay in IDLE.
- **Period start:**
  - Load the active lengths.
  - Enter HIGH if `high_len`≠0; otherwise enter LOW.
- **HIGH:**
  - `cnt_out`=1 for exactly `high_len` cycles.
  - Then enter LOW, or end the period if `low_len`=0.
- **LOW:**
  - `cnt_out`=0 for exactly `low_len` cycles.
  - Then end the period.
- **Period end:**
  - `period_done` is asserted on the last cycle of the period.
  - `periods` increments, saturating at all-ones.
  - Start a new period only if all three hold: `run`=1, `n_periods`=0 or `periods`+1 < `n_periods`, and the shadow lengths are not both zero.
  - Otherwise return to IDLE.
  - If the shadow lengths are both zero at this point, also set `cfg_err`.
- **`en_out`:** 1 in every HIGH and LOW cycle. It goes low together with the return to IDLE. Consecutive periods produce no gap.
- **`run` dropping mid-period:** the current period completes in full. No truncated phases are ever emitted.
- **`cfg_err`:** cleared only by `reset`, or by a `load` whose lengths are not both zero.

## Timing
- All outputs are registered.
- **Start latency:** `run` is sampled 1 in IDLE at edge N; the first HIGH cycle (`cnt_out`=1, `en_out`=1, `busy`=1) is visible after edge N+1.
- **Period length:** exactly `high_len`+`low_len` cycles. There is no dead cycle between periods.
- **`period_done`** is coincident with the final LOW cycle, or with the final HIGH cycle when `low_len`=0.
- **`periods`** updates on the edge that ends the period. It is visible in the cycle after `period_done`.
- **Stop:**
  - `busy`/`en_out` fall on the edge after the last LOW cycle.
  - A new start requires at least one IDLE cycle.
- **Length 1** gives a single-cycle phase. A maximum length of 2^24−1 must not wrap.
- **`reset` mid-operation:** takes effect on the next edge; all outputs are 0 in the following cycle.

## Test plan
- `load` high=3, low=5; `n_periods`=2; `run`=1 → `cnt_out` pattern 1,1,1,0,0,0,0,0 repeated twice; `en_out` high for 16 cycles; `period_done` at cycles 8 and 16; `periods`=2; back to IDLE.
- high=1, low=1, `n_periods`=0, `run` held for 10 cycles then dropped mid-HIGH → alternating 1,0 pattern; the final period completes its LOW phase; `busy` falls one edge later.
- high=4, low=0 for 3 periods → `cnt_out` constantly 1 for 12 cycles; `period_done` every 4th cycle.
- high=0, low=0, `run`=1 → `cfg_err`=1 and `busy` stays 0; then `load` 2/2 → `cfg_err` clears and generation starts.
- `load` of 6/6 issued mid-period while running 2/3 → the current period stays 2/3; the next period is 6/6. A `load` on the period-start edge is applied immediately.
- `reset` asserted during LOW of a 1000/1000 run → next cycle all outputs 0 and `periods`=0; a restart without `load` gives `cfg_err`=1.
